// File: rtl/fetch_queue.sv
// Instruction-fetch front end: sequential PC generation, memory handshake
// absorption and a DEPTH-entry {pc, inst} queue feeding decode.
module fetch_queue #(
    parameter int                XLEN     = 32,
    parameter int                DEPTH    = 4,
    parameter logic [XLEN-1:0]   RESET_PC = '0,
    parameter logic [XLEN-1:0]   NOP_INST = 32'h0000_0013
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic [XLEN-1:0]          iaddr,
    output logic                     ireq,
    input  logic [XLEN-1:0]          idata,
    input  logic                     iready_n,
    input  logic                     redirect_valid,
    input  logic [XLEN-1:0]          redirect_pc,
    input  logic                     deq_ready,
    output logic                     deq_valid,
    output logic [XLEN-1:0]          deq_inst,
    output logic [XLEN-1:0]          deq_pc,
    output logic [XLEN-1:0]          deq_pcp4,
    output logic [4:0]               deq_rs1,
    output logic [4:0]               deq_rs2,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Handshakes: a word is taken from memory when ireq && !iready_n, and an
    // entry leaves to decode when deq_valid && deq_ready; redirect_valid
    // suppresses both and flushes, rst overrides everything.

    logic [XLEN-1:0] mem_pc   [DEPTH];
    logic [XLEN-1:0] mem_inst [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] held_pc;
    logic            push;
    logic            pop;

    assign iaddr     = fetch_pc;
    assign ireq      = !rst && (count != CW'(DEPTH));
    assign deq_valid = (count != '0);
    assign push      = ireq && !iready_n && !redirect_valid;
    assign pop       = deq_valid && deq_ready && !redirect_valid;

    // When empty, the PC keeps showing whatever head was last presented.
    assign deq_pc    = deq_valid ? mem_pc[rd_ptr] : held_pc;
    assign deq_inst  = deq_valid ? mem_inst[rd_ptr] : NOP_INST;
    assign deq_pcp4  = deq_pc + XLEN'(4);
    assign deq_rs1   = deq_inst[19:15];
    assign deq_rs2   = deq_inst[24:20];

    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc[wr_ptr]   <= fetch_pc;
            mem_inst[wr_ptr] <= idata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            held_pc  <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_pc;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            held_pc  <= deq_pc;
        end else begin
            held_pc <= deq_pc;
            if (push) begin
                wr_ptr   <= wr_ptr + PW'(1);
                fetch_pc <= fetch_pc + XLEN'(4);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Directed, table-driven bench for fetch_queue (RESET_PC=0x100, DEPTH=4).
module tb_fetch_queue;
    localparam int XLEN = 32;
    localparam int DEPTH = 4;
    localparam logic [31:0] RPC = 32'h0000_0100;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] iaddr;
    logic        ireq;
    logic [31:0] idata;
    logic        iready_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        deq_ready;
    logic        deq_valid;
    logic [31:0] deq_inst;
    logic [31:0] deq_pc;
    logic [31:0] deq_pcp4;
    logic [4:0]  deq_rs1;
    logic [4:0]  deq_rs2;
    logic [2:0]  count;

    fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RPC), .NOP_INST(NOP)) dut (
        .clk(clk), .rst(rst), .iaddr(iaddr), .ireq(ireq), .idata(idata),
        .iready_n(iready_n), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .deq_ready(deq_ready), .deq_valid(deq_valid),
        .deq_inst(deq_inst), .deq_pc(deq_pc), .deq_pcp4(deq_pcp4),
        .deq_rs1(deq_rs1), .deq_rs2(deq_rs2), .count(count)
    );

    always #5 clk = ~clk;

    // Memory model: each address returns a distinct word.
    function automatic logic [31:0] word_for(input logic [31:0] a);
        return (a << 13) ^ (a >> 7) ^ 32'h0000_0033;
    endfunction

    always_comb idata = word_for(iaddr);

    typedef struct {
        logic        rst;
        logic        rdy_n;
        logic        redir;
        logic [31:0] rpc;
        logic        dr;
        logic [31:0] ia;
        logic        ir;
        logic        dv;
        logic [31:0] pc;
        logic [2:0]  cnt;
    } vec_t;

    vec_t vecs[$];
    int   n_total = 0;
    int   n_pass  = 0;

    task automatic add(input logic r, input logic rn, input logic rd, input logic [31:0] rp,
                       input logic dr, input logic [31:0] ia, input logic ir, input logic dv,
                       input logic [31:0] pc, input logic [2:0] cnt);
        vec_t v;
        v.rst = r; v.rdy_n = rn; v.redir = rd; v.rpc = rp; v.dr = dr;
        v.ia = ia; v.ir = ir; v.dv = dv; v.pc = pc; v.cnt = cnt;
        vecs.push_back(v);
    endtask

    task automatic check(input int row, input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL row%0d %s: got %h expected %h", row, name, act, exp);
    endtask

    initial begin
        logic [31:0] e_inst;
        rst = 1'b1; iready_n = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; deq_ready = 1'b0;

        // Stimulus table: inputs, then expected outputs for that same cycle.
        //   rst rdy_n redir rpc dr | iaddr ireq dv deq_pc count
        // Steady streaming with decode always ready.
        add(0, 0, 0, 0, 1, 32'h100, 1, 0, 32'h000, 0);
        add(0, 0, 0, 0, 1, 32'h104, 1, 1, 32'h100, 1);
        add(0, 0, 0, 0, 1, 32'h108, 1, 1, 32'h104, 1);
        add(0, 0, 0, 0, 1, 32'h10c, 1, 1, 32'h108, 1);
        add(1, 0, 0, 0, 1, 32'h110, 0, 1, 32'h10c, 1);
        // Decode stalled: fill to DEPTH, then a single pop.
        add(0, 0, 0, 0, 0, 32'h100, 1, 0, 32'h000, 0);
        add(0, 0, 0, 0, 0, 32'h104, 1, 1, 32'h100, 1);
        add(0, 0, 0, 0, 0, 32'h108, 1, 1, 32'h100, 2);
        add(0, 0, 0, 0, 0, 32'h10c, 1, 1, 32'h100, 3);
        add(0, 0, 0, 0, 0, 32'h110, 0, 1, 32'h100, 4);
        add(0, 0, 0, 0, 0, 32'h110, 0, 1, 32'h100, 4);
        add(0, 0, 0, 0, 1, 32'h110, 0, 1, 32'h100, 4);
        add(0, 0, 0, 0, 0, 32'h110, 1, 1, 32'h104, 3);
        // Five memory wait cycles mid-stream.
        add(0, 1, 0, 0, 1, 32'h114, 0, 1, 32'h104, 4);
        for (int i = 0; i < 4; i++) add(0, 1, 0, 0, 0, 32'h114, 1, 1, 32'h108, 3);
        add(0, 0, 0, 0, 1, 32'h114, 1, 1, 32'h108, 3);
        add(0, 0, 0, 0, 1, 32'h118, 1, 1, 32'h10c, 3);
        add(0, 0, 0, 0, 1, 32'h11c, 1, 1, 32'h110, 3);
        // Redirect with three entries queued and a word returning.
        add(0, 0, 1, 32'h2000, 1, 32'h120, 1, 1, 32'h114, 3);
        add(0, 1, 0, 0, 1, 32'h2000, 1, 0, 32'h114, 0);
        add(0, 0, 0, 0, 0, 32'h2000, 1, 0, 32'h114, 0);
        add(0, 0, 0, 0, 0, 32'h2004, 1, 1, 32'h2000, 1);
        // Simultaneous push and pop at occupancy 2, wrapping pointers.
        for (int k = 0; k < 10; k++)
            add(0, 0, 0, 0, 1, 32'h2008 + 4 * k, 1, 1, 32'h2000 + 4 * k, 2);
        // Fill, stall memory, then reset.
        add(0, 0, 0, 0, 0, 32'h2030, 1, 1, 32'h2028, 2);
        add(0, 0, 0, 0, 0, 32'h2034, 1, 1, 32'h2028, 3);
        add(0, 1, 0, 0, 0, 32'h2038, 0, 1, 32'h2028, 4);
        add(1, 1, 0, 0, 0, 32'h2038, 0, 1, 32'h2028, 4);
        add(0, 0, 0, 0, 0, 32'h100, 1, 0, 32'h000, 0);
        // First new entry visible; redirect to the top of the address space.
        add(0, 1, 1, 32'hFFFF_FFFC, 0, 32'h104, 1, 1, 32'h100, 1);
        add(0, 0, 0, 0, 0, 32'hFFFF_FFFC, 1, 0, 32'h100, 0);
        add(0, 1, 0, 0, 0, 32'h0000_0000, 1, 1, 32'hFFFF_FFFC, 1);

        // Reset prologue: ireq must stay low while rst is asserted.
        @(posedge clk);
        @(negedge clk);
        #1;
        check(-1, "ireq_in_reset", 32'(ireq), 32'h0);
        check(-1, "count_reset", 32'(count), 32'h0);

        for (int r = 0; r < vecs.size(); r++) begin
            @(negedge clk);
            rst = vecs[r].rst;
            iready_n = vecs[r].rdy_n;
            redirect_valid = vecs[r].redir;
            redirect_pc = vecs[r].rpc;
            deq_ready = vecs[r].dr;
            #1;
            e_inst = vecs[r].dv ? word_for(vecs[r].pc) : NOP;
            check(r, "iaddr", iaddr, vecs[r].ia);
            check(r, "ireq", 32'(ireq), 32'(vecs[r].ir));
            check(r, "deq_valid", 32'(deq_valid), 32'(vecs[r].dv));
            check(r, "count", 32'(count), 32'(vecs[r].cnt));
            check(r, "deq_pc", deq_pc, vecs[r].pc);
            check(r, "deq_pcp4", deq_pcp4, vecs[r].pc + 32'd4);
            check(r, "deq_inst", deq_inst, e_inst);
            check(r, "deq_rs1", 32'(deq_rs1), 32'(e_inst[19:15]));
            check(r, "deq_rs2", 32'(deq_rs2), 32'(e_inst[24:20]));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
